// File: rtl/traffic_request_gen.sv
// traffic_request_gen: per-lane queue/age tracking and one-hot switch requests to the traffic controller (optional starvation logic under TRAFFIC_REQ_STARVE_EN)
module traffic_request_gen #(
  parameter int unsigned Q_W = 4,
  parameter int unsigned AGE_W = 8,
  parameter logic [AGE_W-1:0] MAX_WAIT = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_arrive,
  input  logic [3:0] car_depart,
  input  logic [3:0] light_en,
  output logic       switch_to_a,
  output logic       switch_to_b,
  output logic       switch_to_c,
  output logic       switch_to_d,
  output logic [3:0] q_empty,
  output logic [3:0] starve
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [Q_W-1:0] q_q [4];
  logic [Q_W-1:0] q_d [4];
  logic [1:0] rr_q, rr_d, tgt_q, tgt_d, sel, lk;
  logic [3:0] is_green, nz, acc, st, cand, pool;
  logic [Q_W-1:0] best;
  logic green_v, found, n1, n2;
  // lane-indexed views (0=A..3=D) and saturating queue next state
  always_comb begin
    green_v = $onehot(light_en);
    for (int l = 0; l < 4; l++) begin
      is_green[l] = green_v && light_en[3-l];
      nz[l] = q_q[l] != '0;
      acc[l] = car_depart[3-l] && is_green[l] && nz[l];
      q_d[l] = (car_arrive[3-l] && !acc[l]) ? (&q_q[l] ? q_q[l] : q_q[l] + Q_W'(1)) :
               (acc[l] && !car_arrive[3-l]) ? q_q[l] - Q_W'(1) : q_q[l];
      q_empty[3-l] = !nz[l];
      starve[3-l] = st[l];
    end
  end
`ifdef TRAFFIC_REQ_STARVE_EN
  logic [AGE_W-1:0] age_q [4];
  // waiting-lane age counters, cleared while green or empty
  always_ff @(posedge clk or posedge rst)
    for (int l = 0; l < 4; l++)
      age_q[l] <= rst ? '0 : (is_green[l] || !nz[l]) ? '0 :
                  (&age_q[l] ? age_q[l] : age_q[l] + AGE_W'(1));
  // starvation flags from registered ages
  always_comb
    for (int l = 0; l < 4; l++) st[l] = age_q[l] >= MAX_WAIT;
`else
  assign st = '0;
`endif
  // need detection and target pick: largest queue, ties to first lane from rr_q
  always_comb begin
    cand = nz & ~is_green;
    n1 = |(is_green & ~nz) && |cand;
    n2 = |(st & ~is_green);
    pool = |(cand & st) ? (cand & st) : cand;
    found = 1'b0;
    sel = rr_q;
    best = '0;
    lk = rr_q;
    for (int k = 0; k < 4; k++) begin
      lk = rr_q + 2'(k);
      if (pool[lk] && (!found || q_q[lk] > best)) begin
        found = 1'b1;
        sel = lk;
        best = q_q[lk];
      end
    end
  end
  // request FSM next state: latch target in IDLE, hold until grant in REQ
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    rr_d = rr_q;
    if (state_q == IDLE) begin
      if ((n1 || n2) && found) begin
        state_d = REQ;
        tgt_d = sel;
      end
    end else if (light_en == (4'b1000 >> tgt_q)) begin
      state_d = IDLE;
      rr_d = tgt_q + 2'd1;
    end
  end
  // state, target, round-robin pointer and queue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q <= 2'd0;
      rr_q <= 2'd0;
      for (int l = 0; l < 4; l++) q_q[l] <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      rr_q <= rr_d;
      for (int l = 0; l < 4; l++) q_q[l] <= q_d[l];
    end
  end
  assign switch_to_a = state_q == REQ && tgt_q == 2'd0;
  assign switch_to_b = state_q == REQ && tgt_q == 2'd1;
  assign switch_to_c = state_q == REQ && tgt_q == 2'd2;
  assign switch_to_d = state_q == REQ && tgt_q == 2'd3;
endmodule
